// File: rtl/tdc_interval.sv
// tdc_interval
// Time-to-digital interval measurement. A free-running coarse counter is
// concatenated with the upstream 5-bit fine phase code to timestamp start and
// stop events. The interval (stop - start, modulo 2^(CNT_W+5)) is reported in
// fine LSBs (32 LSB = 1 clk). A start with no stop for TIMEOUT armed cycles
// reports an overflow instead. The result is held until it is accepted.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start_pulse  single-cycle start event (clk-synchronous)
//   stop_pulse   single-cycle stop event (clk-synchronous)
//   fine_code    fine phase code, valid with either pulse
//   out_ready    downstream accepts the result
//   out_valid    result held and available
//   out_interval measured interval in fine LSBs
//   out_ovf      result is a timeout, not a measurement
//   busy         high in ARMED or HOLD
//
// state | meaning
// IDLE  | waiting for start; stop alone is ignored
// ARMED | start captured, elapsed counter running, waiting for stop/timeout
// HOLD  | result presented, waiting for out_valid && out_ready

module tdc_interval #(
   parameter int CNT_W   = 11,
   parameter int TIMEOUT = 2000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_pulse,
   input  logic               stop_pulse,
   input  logic [4:0]         fine_code,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [CNT_W+4:0]   out_interval,
   output logic               out_ovf,
   output logic               busy
);

   localparam int TW   = CNT_W + 5;
   localparam int EL_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  coarse_q;
   logic [EL_W-1:0]   elapsed_q, elapsed_d;
   logic [TW-1:0]     t_start_q, t_start_d;
   logic              valid_q, valid_d;
   logic [TW-1:0]     interval_q, interval_d;
   logic              ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic [TW-1:0]     t_now;

   assign t_now = {coarse_q, fine_code};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         coarse_q   <= '0;
         elapsed_q  <= '0;
         t_start_q  <= '0;
         valid_q    <= 1'b0;
         interval_q <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         coarse_q   <= coarse_q + 1'b1;
         elapsed_q  <= elapsed_d;
         t_start_q  <= t_start_d;
         valid_q    <= valid_d;
         interval_q <= interval_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      elapsed_d  = elapsed_q;
      t_start_d  = t_start_q;
      valid_d    = valid_q;
      interval_d = interval_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            // start wins over a coincident stop
            if (start_pulse) begin
               state_d   = S_ARMED;
               t_start_d = t_now;
               elapsed_d = EL_W'(1);
            end
         end
         S_ARMED: begin
            elapsed_d = elapsed_q + 1'b1;
            // stop wins over a coincident timeout
            if (stop_pulse) begin
               state_d    = S_HOLD;
               interval_d = t_now - t_start_q;
               ovf_d      = 1'b0;
               valid_d    = 1'b1;
               elapsed_d  = '0;
            end else if (elapsed_q == EL_W'(TIMEOUT)) begin
               state_d    = S_HOLD;
               interval_d = '1;
               ovf_d      = 1'b1;
               valid_d    = 1'b1;
               elapsed_d  = '0;
            end
         end
         S_HOLD: begin
            if (valid_q && out_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // registered alongside the state so busy tracks it cycle-for-cycle
      busy_d = (state_d != S_IDLE);
   end

   assign out_valid    = valid_q;
   assign out_interval = interval_q;
   assign out_ovf      = ovf_q;
   assign busy         = busy_q;

endmodule
